// File: rtl/stream_pkg.sv
// Shared stream-width-conversion types: FSM state encoding and the keep clamp.
// Used by both stream_downsize and stream_upsize.
package stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } stream_state_t;

    // Limit a keep count to the number of elements a wide word actually has.
    function automatic logic [31:0] keep_clamp(input logic [31:0] keep, input logic [31:0] ratio);
        return (keep > ratio) ? ratio : keep;
    endfunction

endpackage

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: one wide word (T_DATA_RATIO elements) becomes keep narrow beats, element 0 first.
// First narrow beat 1 cycle after acceptance; stalls hold the beat; STREAM_DOWNSIZE_BACK2BACK_EN allows loading on the final beat.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 32,
    parameter int T_DATA_RATIO  = 3,
    parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_RATIO*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_WIDTH_RATIO:0]               s_keep_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);

    localparam int KW = T_WIDTH_RATIO + 1;
    localparam int DW = T_DATA_RATIO * T_DATA_WIDTH;

    stream_state_t   state_q, state_d;
    logic [KW-1:0]   idx_q, idx_d;
    logic [KW-1:0]   keep_q, keep_c;
    logic [DW-1:0]   data_q;
    logic            last_q;
    logic            load;
    logic            accept;
    logic            at_final;

    assign keep_c   = KW'(keep_clamp(32'(s_keep_i), 32'(T_DATA_RATIO)));
    assign at_final = (idx_q == (keep_q - KW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                data_q <= s_data_i;
                keep_q <= keep_c;
                last_q <= s_last_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load      = 1'b0;
        accept    = 1'b0;
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready_o = !rst;
                accept    = s_valid_i && s_ready_o;
                // A keep=0 word is swallowed here without leaving IDLE.
                if (accept && (keep_c != '0)) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                m_valid_o = 1'b1;
                m_last_o  = last_q && at_final;
`ifdef STREAM_DOWNSIZE_BACK2BACK_EN
                s_ready_o = !rst && at_final && m_ready_i;
`endif
                accept    = s_valid_i && s_ready_o;
                if (m_ready_i && at_final) begin
                    idx_d = '0;
                    if (accept && (keep_c != '0)) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (m_ready_i) begin
                    idx_d = idx_q + KW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_data_o = '0;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            if (idx_q == KW'(i)) begin
                m_data_o = data_q[i*T_DATA_WIDTH +: T_DATA_WIDTH];
            end
        end
    end

endmodule
